vdp_port_ctrl: RTL and testbench
================================

Name: vdp_port_ctrl

Overview:
- CPU-side I/O controller for the TMS9918-style video block. Decodes accesses to the data port (0x98) and control port (0x99).
- Holds the 14-bit auto-incrementing VRAM address, the two-byte control latch, VDP registers R0–R7, the read-ahead buffer and the status register.
- Sequences all CPU VRAM traffic over a req/ack handshake to the video block's VRAM port.
- Sits between the Z80 bus decode and the video module; replaces the ad-hoc port logic in the top level.

Parameters:
- ADDR_W, 14, VRAM address width; wraps at 2^ADDR_W.
- NREGS, 8, number of VDP registers; index = low log2(NREGS) bits of the register-select byte.

Ports:
- clk  in  1  system clock (cpuClock domain)
- reset  in  1  asynchronous, active-high reset
- io_ce  in  1  CPU clock-edge strobe; port accesses are sampled only when high
- port_sel  in  1  0 = data port 0x98, 1 = control port 0x99
- io_wr  in  1  CPU I/O write to the selected port (already decoded)
- io_rd  in  1  CPU I/O read from the selected port
- din  in  8  CPU write data
- dout  out  8  CPU read data (read buffer or status)
- wait_n  out  1  low stalls the CPU while a VRAM transfer is pending
- vram_req  out  1  VRAM transfer request, held until ack
- vram_we  out  1  1 = write, 0 = read; valid while vram_req
- vram_addr  out  ADDR_W  transfer address; stable while vram_req
- vram_wdata  out  8  write data; stable while vram_req
- vram_rdata  in  8  read data; valid in the cycle of vram_ack
- vram_ack  in  1  one-cycle completion pulse
- vblank  in  1  one-cycle frame-end pulse
- spr_coll  in  1  sprite collision pulse
- spr_fifth  in  1  fifth-sprite pulse
- spr_fifth_num  in  5  sprite number accompanying spr_fifth
- regs  out  8*NREGS  R0..R7 flattened; R0 occupies bits [7:0]
- int_n  out  1  active-low interrupt to the CPU

Behaviour:
- Reset values:
  - regs = 0, addr = 0, latch byte = 0, latch flag = 0
  - read buffer = 0, status = 0, dout = 0
  - vram_req = 0, vram_we = 0, wait_n = 1, int_n = 1
  - FSM = IDLE
- Access acceptance:
  - An access is the io_ce cycle with io_wr or io_rd high.
  - It is accepted only when FSM = IDLE.
  - Otherwise wait_n = 0 combinationally, the CPU holds the bus, and the access is accepted on the first io_ce cycle with FSM = IDLE.
- FSM states: IDLE, RD_PEND, WR_PEND.
  - IDLE → RD_PEND or WR_PEND on issue; vram_req rises the next cycle.
  - Pending → IDLE on vram_ack.
  - On a read ack, the read buffer takes vram_rdata.
  - vram_req drops in the cycle after ack.
- Control-port write:
  - Latch flag = 0: store din in the latch byte; flag ← 1.
  - Latch flag = 1, flag ← 0, then by din[7:6]:
    - 00: addr ← {din[5:0], latch}; issue prefetch read at that address; addr ← addr + 1.
    - 01: addr ← {din[5:0], latch}; no transfer.
    - 1x: R[din[2:0]] ← latch.
- Data-port write:
  - Issue a VRAM write of din at addr; addr ← addr + 1.
  - Read buffer ← din.
  - Latch flag ← 0.
- Data-port read:
  - dout = read buffer (registered at acceptance).
  - Issue a prefetch read at addr; addr ← addr + 1; latch flag ← 0.
- Control-port read:
  - dout = status.
  - Afterwards status bits 7 and 5 clear; latch flag ← 0.
- Status layout: bit7 F (set by vblank), bit6 5S (set by spr_fifth), bit5 C (set by spr_coll), bits4:0 fifth-sprite number.
  - Bits 4:0 load only while 5S = 0.
  - Bit6 clears on status read.
- Address wrap: 0x3FFF + 1 → 0x0000.
- Simultaneous status read and set pulse: dout returns the pre-update value; the set wins, so the bit stays 1.
- Reset mid-transfer: vram_req drops immediately and the ack is ignored.
- Unmatched ack in IDLE is ignored.

Optional Feature:
- VDP_IRQ_EN defined: int_n = !(F & R1[5]), registered; deasserts the cycle after the status read clears F.
- VDP_IRQ_EN undefined: int_n is constant 1; F and the other status bits still operate.

Decomposition:
- Package vdp_pkg holds:
  - FSM state enum
  - control command codes CMD_RD_SETUP = 2'b00, CMD_WR_SETUP = 2'b01, CMD_REG = 2'b1x
  - port select constants
  - status bit indices
- One sub-module, vdp_status_reg: set pulses, read-clear, fifth-sprite number capture, IRQ generation.

Test Plan:
- Write 0x00 then 0x40 to 0x99; write 0xAA, 0x55 to 0x98 → VRAM writes 0xAA@0x0000, 0x55@0x0001; addr = 0x0002.
- Write 0x34, 0x12 to 0x99 with VRAM preloaded 0x77@0x1234, 0x88@0x1235; read 0x98 twice → 0x77, then 0x88; read requests at 0x1234, 0x1235, 0x1236.
- Write 0xE0 then 0x81 to 0x99 → R1 = 0xE0; no VRAM request.
- Set addr 0x3FFF via write setup; write 0x5A to 0x98 → write at 0x3FFF; addr = 0x0000.
- Delay ack 5 cycles during a pending write; issue a second data write → wait_n low until the ack; second write issued afterwards at the next address.
- With VDP_IRQ_EN, R1 = 0x20: pulse vblank → int_n = 0; read 0x99 → dout bit7 = 1, then int_n = 1. Status read in the same cycle as vblank → dout bit7 = 0, F = 1 afterwards.

Source files
------------

// File: rtl/vdp_pkg.sv
// ----------------------------------------------------------------------------
// vdp_pkg
// Shared definitions for the TMS9918-style CPU port controller:
//   - vdp_state_e : CPU-side VRAM transfer sequencer states
//   - CMD_*       : command codes carried in din[7:6] of the second control byte
//   - PORT_*      : port_sel encodings (0x98 data, 0x99 control)
//   - ST_*        : bit positions inside the status register
// ----------------------------------------------------------------------------
package vdp_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_PEND = 2'd1,
    ST_WR_PEND = 2'd2
  } vdp_state_e;

  // Second control byte, bits [7:6]
  localparam logic [1:0] CMD_RD_SETUP = 2'b00;
  localparam logic [1:0] CMD_WR_SETUP = 2'b01;
  localparam logic [1:0] CMD_REG      = 2'b1x;  // bit 6 is a don't-care

  localparam logic PORT_DATA = 1'b0;  // 0x98
  localparam logic PORT_CTRL = 1'b1;  // 0x99

  // Status register layout
  localparam int ST_F      = 7;  // frame flag (vblank)
  localparam int ST_5S     = 6;  // fifth sprite flag
  localparam int ST_C      = 5;  // sprite collision flag
  localparam int ST_NUM_HI = 4;  // fifth sprite number, bits [4:0]
  localparam int ST_NUM_LO = 0;

endpackage

// File: rtl/vdp_status_reg.sv
// ----------------------------------------------------------------------------
// vdp_status_reg
// VDP status register: sticky F / 5S / C flags set by one-cycle pulses from the
// video block, cleared by a CPU status read, plus the fifth-sprite number that
// is captured only while 5S is clear. Also produces the CPU interrupt.
//
// Optional build macro VDP_IRQ_EN:
//   defined   : o_int_n = !(F & i_irq_en), registered
//   undefined : o_int_n is constant 1
//
// Ports:
//   clk, reset      clock, asynchronous active-high reset
//   i_clr           status read accepted this cycle (clears F, 5S, C)
//   i_vblank        frame-end pulse, sets F
//   i_coll          sprite collision pulse, sets C
//   i_fifth         fifth-sprite pulse, sets 5S
//   i_fifth_num     sprite number accompanying i_fifth
//   i_irq_en        interrupt enable (R1 bit 5)
//   o_status        current status byte (pre-update value during a read)
//   o_int_n         active-low interrupt
// ----------------------------------------------------------------------------
module vdp_status_reg
  import vdp_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       i_clr,
  input  logic       i_vblank,
  input  logic       i_coll,
  input  logic       i_fifth,
  input  logic [4:0] i_fifth_num,
  input  logic       i_irq_en,
  output logic [7:0] o_status,
  output logic       o_int_n
);

  logic       r_f;
  logic       r_5s;
  logic       r_c;
  logic [4:0] r_num;

  // A set pulse coinciding with a read-clear takes priority, so no event is lost.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_f   <= 1'b0;
      r_5s  <= 1'b0;
      r_c   <= 1'b0;
      r_num <= '0;
    end else begin
      if (i_vblank)   r_f <= 1'b1;
      else if (i_clr) r_f <= 1'b0;

      if (i_fifth)    r_5s <= 1'b1;
      else if (i_clr) r_5s <= 1'b0;

      if (i_coll)     r_c <= 1'b1;
      else if (i_clr) r_c <= 1'b0;

      // Keep the first fifth-sprite number until software acknowledges it
      if (i_fifth && !r_5s) r_num <= i_fifth_num;
    end
  end

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    o_status                      = '0;
    o_status[ST_F]                = r_f;
    o_status[ST_5S]               = r_5s;
    o_status[ST_C]                = r_c;
    o_status[ST_NUM_HI:ST_NUM_LO] = r_num;
  end

`ifdef VDP_IRQ_EN
  logic r_int_n;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_int_n <= 1'b1;
    else       r_int_n <= !(r_f && i_irq_en);
  end

  assign o_int_n = r_int_n;
`else
  logic w_unused_irq_en;
  assign w_unused_irq_en = i_irq_en;
  assign o_int_n         = 1'b1;
`endif

endmodule

// File: rtl/vdp_port_ctrl.sv
// ----------------------------------------------------------------------------
// vdp_port_ctrl
// CPU-side I/O controller of the TMS9918-style video block. Decodes accesses
// to the data port (0x98) and control port (0x99), holds the auto-incrementing
// VRAM address, two-byte control latch, registers R0..R(NREGS-1), read-ahead
// buffer and status register, and sequences CPU VRAM traffic over a req/ack
// handshake. One transfer may be outstanding; further accesses stall the CPU
// through wait_n until the transfer is acknowledged.
//
// Optional build macro VDP_IRQ_EN enables int_n (see vdp_status_reg).
//
// Ports:
//   clk, reset             clock, asynchronous active-high reset
//   io_ce                  CPU clock-edge strobe qualifying io_wr / io_rd
//   port_sel               0 = data port, 1 = control port
//   io_wr, io_rd, din      CPU access and write data
//   dout                   registered CPU read data (read buffer or status)
//   wait_n                 low while an access is blocked by a pending transfer
//   vram_req/we/addr/wdata transfer request, held until vram_ack
//   vram_rdata, vram_ack   read data and one-cycle completion pulse
//   vblank, spr_coll,
//   spr_fifth(_num)        status set pulses from the video block
//   regs                   R0..R(NREGS-1) flattened, R0 in bits [7:0]
//   int_n                  active-low CPU interrupt
// ----------------------------------------------------------------------------
module vdp_port_ctrl
  import vdp_pkg::*;
#(
  parameter int ADDR_W = 14,
  parameter int NREGS  = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 io_ce,
  input  logic                 port_sel,
  input  logic                 io_wr,
  input  logic                 io_rd,
  input  logic [7:0]           din,
  output logic [7:0]           dout,
  output logic                 wait_n,
  output logic                 vram_req,
  output logic                 vram_we,
  output logic [ADDR_W-1:0]    vram_addr,
  output logic [7:0]           vram_wdata,
  input  logic [7:0]           vram_rdata,
  input  logic                 vram_ack,
  input  logic                 vblank,
  input  logic                 spr_coll,
  input  logic                 spr_fifth,
  input  logic [4:0]           spr_fifth_num,
  output logic [8*NREGS-1:0]   regs,
  output logic                 int_n
);

  localparam int RIDX_W = (NREGS > 1) ? $clog2(NREGS) : 1;

  vdp_state_e        r_state;
  vdp_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_addr;
  logic [ADDR_W-1:0] r_xfer_addr;
  logic [7:0]        r_wdata;
  logic [7:0]        r_latch;
  logic              r_flag;
  logic [7:0]        r_rbuf;
  logic [7:0]        r_dout;
  logic [7:0]        r_regs [NREGS];
  logic [7:0]        w_status;

  logic              w_access;
  logic              w_idle;
  logic              w_accept;
  logic              w_is_wr;
  logic              w_data_wr;
  logic              w_data_rd;
  logic              w_ctrl_wr2;
  logic              w_ctrl_rd;
  logic              w_go_rd;
  logic [ADDR_W-1:0] w_setup_addr;

  // Write wins if a malformed cycle asserts both strobes
  assign w_access     = io_ce && (io_wr || io_rd);
  assign w_idle       = (r_state == ST_IDLE);
  assign w_accept     = w_access && w_idle;
  assign w_is_wr      = io_wr;
  assign w_data_wr    = w_accept &&  w_is_wr && (port_sel == PORT_DATA);
  assign w_data_rd    = w_accept && !w_is_wr && (port_sel == PORT_DATA);
  assign w_ctrl_wr2   = w_accept &&  w_is_wr && (port_sel == PORT_CTRL) && r_flag;
  assign w_ctrl_rd    = w_accept && !w_is_wr && (port_sel == PORT_CTRL);
  assign w_setup_addr = ADDR_W'({din[5:0], r_latch});
  assign w_go_rd      = w_data_rd || (w_ctrl_wr2 && (din[7:6] == CMD_RD_SETUP));

  assign wait_n     = !(w_access && !w_idle);
  assign vram_req   = (r_state != ST_IDLE);
  assign vram_we    = (r_state == ST_WR_PEND);
  assign vram_addr  = r_xfer_addr;
  assign vram_wdata = r_wdata;
  assign dout       = r_dout;

  // Transfer sequencer
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: begin
        if (w_data_wr)    w_state_nxt = ST_WR_PEND;
        else if (w_go_rd) w_state_nxt = ST_RD_PEND;
      end
      ST_RD_PEND, ST_WR_PEND: begin
        if (vram_ack) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Port datapath. The register file is only NREGS bytes and must read as
  // zero after reset, so it is reset like ordinary flops.
  // NOTE: this small register array is reset explicitly; large RAMs would not be.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_addr      <= '0;
      r_xfer_addr <= '0;
      r_wdata     <= '0;
      r_latch     <= '0;
      r_flag      <= 1'b0;
      r_rbuf      <= '0;
      r_dout      <= '0;
      for (int i = 0; i < NREGS; i++) r_regs[i] <= '0;
    end else begin
      // Ack is honoured only while a read is pending; a stray ack is ignored
      if (r_state == ST_RD_PEND && vram_ack) r_rbuf <= vram_rdata;

      if (w_data_wr) begin
        r_xfer_addr <= r_addr;
        r_wdata     <= din;
        r_addr      <= r_addr + ADDR_W'(1);
        r_rbuf      <= din;
        r_flag      <= 1'b0;
      end

      if (w_accept && w_is_wr && (port_sel == PORT_CTRL) && !r_flag) begin
        r_latch <= din;
        r_flag  <= 1'b1;
      end

      if (w_ctrl_wr2) begin
        r_flag <= 1'b0;
        if (din[7:6] ==? CMD_REG) begin
          r_regs[din[RIDX_W-1:0]] <= r_latch;
        end else if (din[7:6] == CMD_WR_SETUP) begin
          r_addr <= w_setup_addr;
        end else begin
          // Read setup prefetches at the new address and leaves addr one past it
          r_xfer_addr <= w_setup_addr;
          r_addr      <= w_setup_addr + ADDR_W'(1);
        end
      end

      if (w_data_rd) begin
        r_dout      <= r_rbuf;
        r_xfer_addr <= r_addr;
        r_addr      <= r_addr + ADDR_W'(1);
        r_flag      <= 1'b0;
      end

      if (w_ctrl_rd) begin
        r_dout <= w_status;
        r_flag <= 1'b0;
      end
    end
  end

  always_comb begin
    regs = '0;
    for (int i = 0; i < NREGS; i++) regs[8*i +: 8] = r_regs[i];
  end

  vdp_status_reg u_status (
    .clk         (clk),
    .reset       (reset),
    .i_clr       (w_ctrl_rd),
    .i_vblank    (vblank),
    .i_coll      (spr_coll),
    .i_fifth     (spr_fifth),
    .i_fifth_num (spr_fifth_num),
    .i_irq_en    (r_regs[1][5]),
    .o_status    (w_status),
    .o_int_n     (int_n)
  );

endmodule

// File: tb/tb_vdp_port_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vdp_port_ctrl
// Self-checking bench for vdp_port_ctrl. A VRAM responder with programmable
// ack latency serves the req/ack port; a reference model of the port
// behaviour (address pointer, latch, registers, read buffer, status flags and
// VRAM contents) predicts read data, transfers, registers and int_n.
// int_n expectations follow the VDP_IRQ_EN build macro.
// ----------------------------------------------------------------------------
module tb_vdp_port_ctrl;

  localparam int ADDR_W = 14;
  localparam int NREGS  = 8;
  localparam int MEM_SZ = 1 << ADDR_W;

  logic                clk = 1'b0;
  logic                reset;
  logic                io_ce, port_sel, io_wr, io_rd;
  logic [7:0]          din, dout;
  logic                wait_n, vram_req, vram_we, vram_ack;
  logic [ADDR_W-1:0]   vram_addr;
  logic [7:0]          vram_wdata, vram_rdata;
  logic                vblank, spr_coll, spr_fifth;
  logic [4:0]          spr_fifth_num;
  logic [8*NREGS-1:0]  regs;
  logic                int_n;

  vdp_port_ctrl #(.ADDR_W(ADDR_W), .NREGS(NREGS)) dut (
    .clk(clk), .reset(reset), .io_ce(io_ce), .port_sel(port_sel),
    .io_wr(io_wr), .io_rd(io_rd), .din(din), .dout(dout), .wait_n(wait_n),
    .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr),
    .vram_wdata(vram_wdata), .vram_rdata(vram_rdata), .vram_ack(vram_ack),
    .vblank(vblank), .spr_coll(spr_coll), .spr_fifth(spr_fifth),
    .spr_fifth_num(spr_fifth_num), .regs(regs), .int_n(int_n)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          we;
    int unsigned addr;
    logic [7:0]  data;
  } xfer_t;

  // Environment
  logic [7:0] vram [MEM_SZ];
  xfer_t      act_q [$];
  int         act_ptr   = 0;
  int         ack_count = 0;
  int         ack_delay = 0;
  bit         stray_req = 0;

  // Reference model
  int unsigned m_addr;
  logic [7:0]  m_latch;
  bit          m_flag;
  logic [7:0]  m_regs [NREGS];
  logic [7:0]  m_rbuf;
  bit          m_f, m_5s, m_c;
  logic [4:0]  m_num;
  logic [7:0]  m_mem [MEM_SZ];
  xfer_t       exp_q [$];

  int n_cmp  = 0;
  int n_fail = 0;

  // VRAM responder: acks each request after ack_delay idle cycles
  initial begin
    int cnt;
    cnt        = 0;
    vram_ack   = 1'b0;
    vram_rdata = 8'h00;
    forever begin
      @(negedge clk);
      if (vram_ack) begin
        vram_ack = 1'b0;
      end else if (vram_req && !reset) begin
        if (cnt < ack_delay) begin
          cnt++;
        end else begin
          cnt       = 0;
          vram_ack  = 1'b1;
          ack_count++;
          if (vram_we) begin
            vram[vram_addr] = vram_wdata;
            act_q.push_back('{we: 1'b1, addr: int'(vram_addr), data: vram_wdata});
          end else begin
            vram_rdata = vram[vram_addr];
            act_q.push_back('{we: 1'b0, addr: int'(vram_addr), data: vram_rdata});
          end
        end
      end else begin
        cnt = 0;
        if (stray_req) begin
          stray_req  = 1'b0;
          vram_ack   = 1'b1;
          vram_rdata = 8'hC3;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    m_addr  = 0;
    m_latch = 8'h00;
    m_flag  = 1'b0;
    m_rbuf  = 8'h00;
    m_f     = 1'b0;
    m_5s    = 1'b0;
    m_c     = 1'b0;
    m_num   = 5'd0;
    for (int i = 0; i < NREGS; i++) m_regs[i] = 8'h00;
  endfunction

  function automatic void model_prefetch(input int unsigned a);
    exp_q.push_back('{we: 1'b0, addr: a, data: m_mem[a]});
    m_rbuf = m_mem[a];
  endfunction

  // Returns the byte the CPU should read (don't-care for writes)
  function automatic logic [7:0] model_access(input bit port, input bit wr, input logic [7:0] d);
    logic [7:0]  r;
    int unsigned a;
    r = 8'h00;
    if (wr && !port) begin
      exp_q.push_back('{we: 1'b1, addr: m_addr, data: d});
      m_mem[m_addr] = d;
      m_rbuf        = d;
      m_addr        = (m_addr + 1) % MEM_SZ;
      m_flag        = 1'b0;
    end else if (wr) begin
      if (!m_flag) begin
        m_latch = d;
        m_flag  = 1'b1;
      end else begin
        m_flag = 1'b0;
        a      = int'(d[5:0]) * 256 + int'(m_latch);
        if (d[7])      m_regs[d[2:0]] = m_latch;
        else if (d[6]) m_addr = a;
        else begin
          model_prefetch(a);
          m_addr = (a + 1) % MEM_SZ;
        end
      end
    end else if (!port) begin
      r = m_rbuf;
      model_prefetch(m_addr);
      m_addr = (m_addr + 1) % MEM_SZ;
      m_flag = 1'b0;
    end else begin
      r      = {m_f, m_5s, m_c, m_num};
      m_f    = 1'b0;
      m_5s   = 1'b0;
      m_c    = 1'b0;
      m_flag = 1'b0;
    end
    return r;
  endfunction

  // Drives one CPU access, holding it while wait_n is low; rd is dout after acceptance
  task automatic cpu_access(input bit port, input bit wr, input logic [7:0] d,
                            input bit with_vb, output logic [7:0] rd, output int stall);
    @(negedge clk);
    port_sel = port;
    io_wr    = wr;
    io_rd    = !wr;
    din      = d;
    io_ce    = 1'b1;
    stall    = 0;
    #1;
    while (!wait_n && stall < 200) begin
      stall++;
      @(negedge clk);
      #1;
    end
    check("wait_n_release", wait_n, 1'b1);
    if (with_vb) vblank = 1'b1;
    @(posedge clk);
    @(negedge clk);
    io_wr  = 1'b0;
    io_rd  = 1'b0;
    io_ce  = 1'b0;
    vblank = 1'b0;
    #1 rd = dout;
  endtask

  task automatic drain();
    int n;
    n = 0;
    @(negedge clk);
    while (vram_req && n < 100) begin
      n++;
      @(negedge clk);
    end
    #1;
    check("drain_idle", vram_req, 1'b0);
  endtask

  task automatic check_xfers();
    xfer_t x, y;
    check("xfer_count", act_q.size() - act_ptr, exp_q.size());
    while (exp_q.size() > 0 && act_ptr < act_q.size()) begin
      x = exp_q.pop_front();
      y = act_q[act_ptr];
      act_ptr++;
      check("xfer_we",   y.we,   x.we);
      check("xfer_addr", y.addr, x.addr);
      check("xfer_data", y.data, x.data);
    end
    exp_q.delete();
    act_ptr = act_q.size();
  endtask

  task automatic check_state();
    logic [63:0] er;
    er = '0;
    for (int i = 0; i < NREGS; i++) er[8*i +: 8] = m_regs[i];
    check("regs", regs, er);
`ifdef VDP_IRQ_EN
    check("int_n", int_n, !(m_f && m_regs[1][5]));
`else
    check("int_n", int_n, 1'b1);
`endif
  endtask

  task automatic do_acc(input bit port, input bit wr, input logic [7:0] d, output logic [7:0] got);
    logic [7:0] e;
    int         st;
    e = model_access(port, wr, d);
    cpu_access(port, wr, d, 1'b0, got, st);
    if (!wr) check(port ? "status_read" : "data_read", got, e);
    drain();
    check_xfers();
    check_state();
  endtask

  task automatic pulse(input bit vb, input bit co, input bit fi, input logic [4:0] num);
    @(negedge clk);
    vblank        = vb;
    spr_coll      = co;
    spr_fifth     = fi;
    spr_fifth_num = num;
    @(negedge clk);
    vblank    = 1'b0;
    spr_coll  = 1'b0;
    spr_fifth = 1'b0;
    if (vb) m_f = 1'b1;
    if (co) m_c = 1'b1;
    if (fi) begin
      if (!m_5s) m_num = num;
      m_5s = 1'b1;
    end
  endtask

  initial begin
    logic [7:0] got, e;
    int         st, acks0;

    reset = 1'b1; io_ce = 0; port_sel = 0; io_wr = 0; io_rd = 0; din = 0;
    vblank = 0; spr_coll = 0; spr_fifth = 0; spr_fifth_num = 0;
    for (int i = 0; i < MEM_SZ; i++) begin
      vram[i]  = 8'($urandom);
      m_mem[i] = vram[i];
    end
    model_reset();

    repeat (3) @(negedge clk);
    #1;
    check("rst_vram_req", vram_req, 1'b0);
    check("rst_vram_we",  vram_we,  1'b0);
    check("rst_wait_n",   wait_n,   1'b1);
    check("rst_int_n",    int_n,    1'b1);
    check("rst_dout",     dout,     8'h00);
    check("rst_regs",     regs,     64'h0);
    @(negedge clk);
    reset = 1'b0;

    // Write setup to 0x0000, then two data writes
    do_acc(1, 1, 8'h00, got);
    do_acc(1, 1, 8'h40, got);
    do_acc(0, 1, 8'hAA, got);
    do_acc(0, 1, 8'h55, got);
    check("tp1_vram0", vram[0], 8'hAA);
    check("tp1_vram1", vram[1], 8'h55);
    do_acc(0, 0, 8'h00, got);
    check("tp1_next_addr", act_q[act_q.size()-1].addr, 2);

    // Read setup at 0x1234 and two data reads
    vram[14'h1234] = 8'h77; m_mem[14'h1234] = 8'h77;
    vram[14'h1235] = 8'h88; m_mem[14'h1235] = 8'h88;
    do_acc(1, 1, 8'h34, got);
    do_acc(1, 1, 8'h12, got);
    check("tp2_prefetch_addr", act_q[act_q.size()-1].addr, 32'h1234);
    do_acc(0, 0, 8'h00, got);
    check("tp2_rd0", got, 8'h77);
    do_acc(0, 0, 8'h00, got);
    check("tp2_rd1", got, 8'h88);
    check("tp2_last_addr", act_q[act_q.size()-1].addr, 32'h1236);

    // Register write R1 = 0xE0, no VRAM traffic
    acks0 = ack_count;
    do_acc(1, 1, 8'hE0, got);
    do_acc(1, 1, 8'h81, got);
    check("tp3_r1", regs[15:8], 8'hE0);
    check("tp3_no_xfer", ack_count, acks0);

    // Address wrap
    do_acc(1, 1, 8'hFF, got);
    do_acc(1, 1, 8'h7F, got);
    do_acc(0, 1, 8'h5A, got);
    check("tp4_wr_addr", act_q[act_q.size()-1].addr, 32'h3FFF);
    do_acc(0, 0, 8'h00, got);
    check("tp4_wrapped", act_q[act_q.size()-1].addr, 0);

    // Slow ack: second write stalls until the first is acknowledged
    ack_delay = 5;
    e = model_access(0, 1, 8'h11);
    cpu_access(0, 1, 8'h11, 1'b0, got, st);
    acks0 = ack_count;
    e = model_access(0, 1, 8'h22);
    cpu_access(0, 1, 8'h22, 1'b0, got, st);
    check("tp5_stalled", st > 0, 1'b1);
    check("tp5_release_after_ack", ack_count, acks0 + 1);
    drain();
    check_xfers();
    ack_delay = 0;

    // Frame flag and interrupt
    do_acc(1, 1, 8'h20, got);
    do_acc(1, 1, 8'h81, got);
    pulse(1'b1, 1'b0, 1'b0, 5'd0);
    @(negedge clk);
    #1;
`ifdef VDP_IRQ_EN
    check("tp6_irq_asserted", int_n, 1'b0);
`else
    check("tp6_irq_disabled", int_n, 1'b1);
`endif
    e = model_access(1, 0, 8'h00);
    cpu_access(1, 0, 8'h00, 1'b0, got, st);
    check("tp6_status_f", got[7], 1'b1);
`ifdef VDP_IRQ_EN
    check("tp6_irq_still_low", int_n, 1'b0);
`endif
    @(negedge clk);
    #1;
    check("tp6_irq_released", int_n, 1'b1);
    drain();
    check_state();

    // Status read coinciding with vblank: old value returned, F stays set
    e = model_access(1, 0, 8'h00);
    m_f = 1'b1;
    cpu_access(1, 0, 8'h00, 1'b1, got, st);
    check("tp7_simul_dout", got, e);
    check("tp7_simul_f_clear", got[7], 1'b0);
    drain();
    check_state();
    do_acc(1, 0, 8'h00, got);
    check("tp7_f_kept", got[7], 1'b1);

    // Fifth-sprite number captured once, retained after 5S clears
    pulse(1'b0, 1'b0, 1'b1, 5'd9);
    pulse(1'b0, 1'b1, 1'b1, 5'd3);
    do_acc(1, 0, 8'h00, got);
    check("tp8_fifth", got, 8'h69);
    do_acc(1, 0, 8'h00, got);
    check("tp8_fifth_kept", got, 8'h09);

    // Unmatched ack in IDLE is ignored
    stray_req = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    check("stray_idle", vram_req, 1'b0);
    do_acc(0, 0, 8'h00, got);

    // Randomised traffic
    for (int i = 0; i < 300; i++) begin
      ack_delay = $urandom_range(0, 3);
      case ($urandom_range(0, 5))
        0: do_acc(0, 1, 8'($urandom), got);
        1: do_acc(0, 0, 8'h00, got);
        2: do_acc(1, 1, 8'($urandom), got);
        3: begin
          do_acc(1, 1, 8'($urandom), got);
          do_acc(1, 1, 8'($urandom), got);
        end
        4: do_acc(1, 0, 8'h00, got);
        default: pulse(1'($urandom), 1'($urandom), 1'($urandom), 5'($urandom));
      endcase
    end

    // Reset while a prefetch is outstanding
    ack_delay = 20;
    e = model_access(0, 0, 8'h00);
    cpu_access(0, 0, 8'h00, 1'b0, got, st);
    check("rst_mid_pre_rd", got, e);
    check("rst_mid_pending", vram_req, 1'b1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_mid_req", vram_req, 1'b0);
    check("rst_mid_wait_n", wait_n, 1'b1);
    check("rst_mid_dout", dout, 8'h00);
    check("rst_mid_regs", regs, 64'h0);
    check("rst_mid_int_n", int_n, 1'b1);
    model_reset();
    exp_q.delete();
    act_ptr = act_q.size();
    @(negedge clk);
    reset     = 1'b0;
    ack_delay = 1;
    do_acc(0, 0, 8'h00, got);
    check("post_rst_rbuf", got, 8'h00);
    do_acc(1, 0, 8'h00, got);
    check("post_rst_status", got, 8'h00);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
